decode_cycle: RTL and testbench

//  Stage 2 (ID) of the 5-stage RV32I pipeline; consumes InstrD/PCD/PCPlus4D from the fetch stage.

---
 rtl/riscv_pkg.sv | 45 ++++
 rtl/register_file.sv | 44 ++++
 rtl/decode_cycle.sv | 154 +++++++++++++++
 tb/tb_decode_cycle.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU control encodings, immediate formats.
// Also holds the immediate generator used by the ID stage.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2
    } imm_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       result_src;
        logic       alu_src;
        logic       branch;
        logic [2:0] alu_control;
    } ctrl_t;

    // All formats sign-extend from instr[31]; the B format drops bit 0.
    function automatic logic [XLEN-1:0] imm_ext(input logic [31:0] instr, input imm_t sel);
        logic [XLEN-1:0] imm;
        case (sel)
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            default: imm = {{20{instr[31]}}, instr[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/register_file.sv
// 2-read/1-write architectural register file, x0 reads as zero, async-cleared array.
// Reads are combinational with write-through bypass so a same-cycle writeback is seen.
module register_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ra1_i,
    input  logic [4:0]      ra2_i,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_en;

    assign wr_en = we_i && (wa_i != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // x0 check comes first so a bypass can never leak a value onto x0.
    always_comb begin
        if (ra1_i == 5'd0)                rd1_o = '0;
        else if (wr_en && wa_i == ra1_i)  rd1_o = wd_i;
        else                              rd1_o = regs_q[ra1_i];

        if (ra2_i == 5'd0)                rd2_o = '0;
        else if (wr_en && wa_i == ra2_i)  rd2_o = wd_i;
        else                              rd2_o = regs_q[ra2_i];
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I ID stage: decode, register read, immediate generation, ID/EX register.
// One-cycle latency, loads every edge; FlushE turns the loaded control into a bubble.
module decode_cycle #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            ResultSrcE,
    output logic            ALUSrcE,
    output logic            BranchE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      RS1E,
    output logic [4:0]      RS2E,
    output logic [4:0]      RDE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E
);

    import riscv_pkg::*;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rd1, rd2;

    ctrl_t           ctrl_d, ctrl_q;
    imm_t            imm_sel;
    logic [2:0]      alu_op;
    logic            alu_ok;

    logic [XLEN-1:0] rd1_q, rd2_q, imm_q, pc_q, pc4_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign rs1    = InstrD[19:15];
    assign rs2    = InstrD[24:20];
    assign rd     = InstrD[11:7];

    register_file #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk   (clk),
        .rst_n (rst),
        .ra1_i (rs1),
        .ra2_i (rs2),
        .we_i  (RegWriteW),
        .wa_i  (RDW),
        .wd_i  (ResultW),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

    // funct7[5] selects sub only for register-register ops; addi has no subi twin.
    always_comb begin
        alu_op = ALU_ADD;
        alu_ok = 1'b1;
        case (funct3)
            3'b000:  alu_op = (opcode == OP_R && InstrD[30]) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_op = ALU_AND;
            3'b110:  alu_op = ALU_OR;
            3'b010:  alu_op = ALU_SLT;
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        ctrl_d  = '0;
        imm_sel = IMM_I;
        case (opcode)
            OP_LW: if (funct3 == 3'b010) begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.result_src = 1'b1;
            end
            OP_SW: begin
                imm_sel = IMM_S;
                if (funct3 == 3'b010) begin
                    ctrl_d.mem_write = 1'b1;
                    ctrl_d.alu_src   = 1'b1;
                end
            end
            OP_R: if (alu_ok) begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_control = alu_op;
            end
            OP_I: if (alu_ok) begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_src     = 1'b1;
                ctrl_d.alu_control = alu_op;
            end
            OP_BEQ: begin
                imm_sel = IMM_B;
                if (funct3 == 3'b000) begin
                    ctrl_d.branch      = 1'b1;
                    ctrl_d.alu_control = ALU_SUB;
                end
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            rd_q   <= '0;
            pc_q   <= RESET_PC;
            pc4_q  <= RESET_PC;
        end else begin
            ctrl_q <= FlushE ? '0 : ctrl_d;
            rd1_q  <= rd1;
            rd2_q  <= rd2;
            imm_q  <= imm_ext(InstrD, imm_sel);
            rs1_q  <= rs1;
            rs2_q  <= rs2;
            rd_q   <= rd;
            pc_q   <= PCD;
            pc4_q  <= PCPlus4D;
        end
    end

    assign RegWriteE   = ctrl_q.reg_write;
    assign MemWriteE   = ctrl_q.mem_write;
    assign ResultSrcE  = ctrl_q.result_src;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign BranchE     = ctrl_q.branch;
    assign ALUControlE = ctrl_q.alu_control;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign ImmExtE     = imm_q;
    assign RS1E        = rs1_q;
    assign RS2E        = rs2_q;
    assign RDE         = rd_q;
    assign PCE         = pc_q;
    assign PCPlus4E    = pc4_q;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for the ID stage: decode vectors, register file write/bypass, flush, reset.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RDW;
    logic        RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RS1E, RS2E, RDE;
    logic [7:0]  ctrl;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // {RegWrite, MemWrite, ResultSrc, ALUSrc, Branch, ALUControl[2:0]}
    assign ctrl = {RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, ALUControlE};

    decode_cycle #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RS1E(RS1E), .RS2E(RS2E),
        .RDE(RDE), .PCE(PCE), .PCPlus4E(PCPlus4E)
    );

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        InstrD   = instr;
        PCD      = pc;
        PCPlus4D = pc + 32'd4;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] val);
        RegWriteW = we;
        RDW       = rd;
        ResultW   = val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32'h0, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        FlushE = 1'b0;
        #1 rst = 1'b0;
        #1;
        checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h want %h", ctrl, 8'h00); end
        checks++; if (PCE !== 32'h0 || PCPlus4E !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h/%h want 0/0", PCE, PCPlus4E); end
        checks++; if ({RD1E, RD2E, ImmExtE} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {RD1E, RD2E, ImmExtE}); end
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_alu_decode();
        wb(1'b1, 5'd1, 32'd5);     drive(32'h0000_0013, 32'h10); tick();
        wb(1'b1, 5'd2, 32'd7);     drive(32'h0000_0013, 32'h14); tick();
        wb(1'b0, 5'd0, 32'h0);     drive(32'h0020_81B3, 32'h18); tick();
        checks++; if (RD1E !== 32'd5 || RD2E !== 32'd7) begin errors++; $display("FAIL add_operands: got %h/%h want 5/7", RD1E, RD2E); end
        checks++; if (ctrl !== 8'h80) begin errors++; $display("FAIL add_ctrl: got %h want %h", ctrl, 8'h80); end
        checks++; if ({RS1E, RS2E, RDE} !== {5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL add_idx: got %0d/%0d/%0d want 1/2/3", RS1E, RS2E, RDE); end
        checks++; if (PCE !== 32'h18 || PCPlus4E !== 32'h1C) begin errors++; $display("FAIL add_pc: got %h/%h want 18/1c", PCE, PCPlus4E); end
        drive(32'h4020_81B3, 32'h1C); tick();
        checks++; if (ctrl !== 8'h81) begin errors++; $display("FAIL sub_ctrl: got %h want %h", ctrl, 8'h81); end
        drive(32'h0020_F1B3, 32'h20); tick();
        checks++; if (ctrl !== 8'h82) begin errors++; $display("FAIL and_ctrl: got %h want %h", ctrl, 8'h82); end
        drive(32'h0020_E1B3, 32'h24); tick();
        checks++; if (ctrl !== 8'h83) begin errors++; $display("FAIL or_ctrl: got %h want %h", ctrl, 8'h83); end
        drive(32'h0020_A1B3, 32'h28); tick();
        checks++; if (ctrl !== 8'h85) begin errors++; $display("FAIL slt_ctrl: got %h want %h", ctrl, 8'h85); end
        drive(32'h0020_91B3, 32'h2C); tick();
        checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL sll_bubble: got %h want %h", ctrl, 8'h00); end
        // addi x1,x1,0x400: funct7[5] is set but must not turn into a subtract
        drive(32'h4000_8093, 32'h30); tick();
        checks++; if (ctrl !== 8'h90) begin errors++; $display("FAIL addi_ctrl: got %h want %h", ctrl, 8'h90); end
        checks++; if (ImmExtE !== 32'h400) begin errors++; $display("FAIL addi_imm: got %h want %h", ImmExtE, 32'h400); end
    endtask

    task automatic test_bypass();
        wb(1'b1, 5'd1, 32'hDEAD); drive(32'h0020_81B3, 32'h40); tick();
        checks++; if (RD1E !== 32'hDEAD || RD2E !== 32'd7) begin errors++; $display("FAIL bypass_rd1: got %h/%h want dead/7", RD1E, RD2E); end
        wb(1'b0, 5'd0, 32'h0); tick();
        checks++; if (RD1E !== 32'hDEAD) begin errors++; $display("FAIL stored_rd1: got %h want %h", RD1E, 32'hDEAD); end
        wb(1'b1, 5'd0, 32'h1234); drive(32'h0000_01B3, 32'h44); tick();
        checks++; if (RD1E !== 32'h0 || RD2E !== 32'h0) begin errors++; $display("FAIL x0_bypass: got %h/%h want 0/0", RD1E, RD2E); end
        wb(1'b0, 5'd0, 32'h0); tick();
        checks++; if (RD1E !== 32'h0) begin errors++; $display("FAIL x0_read: got %h want 0", RD1E); end
    endtask

    task automatic test_lw_sw();
        drive(32'hFF81_2283, 32'h50); tick();
        checks++; if (ImmExtE !== 32'hFFFF_FFF8) begin errors++; $display("FAIL lw_imm: got %h want %h", ImmExtE, 32'hFFFF_FFF8); end
        checks++; if (ctrl !== 8'hB0) begin errors++; $display("FAIL lw_ctrl: got %h want %h", ctrl, 8'hB0); end
        checks++; if (RDE !== 5'd5 || RS1E !== 5'd2) begin errors++; $display("FAIL lw_idx: got %0d/%0d want 5/2", RDE, RS1E); end
        drive(32'h0020_A423, 32'h54); tick();
        checks++; if (ImmExtE !== 32'd8) begin errors++; $display("FAIL sw_imm: got %h want %h", ImmExtE, 32'd8); end
        checks++; if (ctrl !== 8'h50) begin errors++; $display("FAIL sw_ctrl: got %h want %h", ctrl, 8'h50); end
    endtask

    task automatic test_beq_flush();
        drive(32'hFE20_8EE3, 32'h60); tick();
        checks++; if (ctrl !== 8'h09) begin errors++; $display("FAIL beq_ctrl: got %h want %h", ctrl, 8'h09); end
        checks++; if (ImmExtE !== 32'hFFFF_FFFC) begin errors++; $display("FAIL beq_imm: got %h want %h", ImmExtE, 32'hFFFF_FFFC); end
        FlushE = 1'b1;
        wb(1'b1, 5'd6, 32'h99);
        drive(32'hFE20_8EE3, 32'h64); tick();
        checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL flush_ctrl: got %h want %h", ctrl, 8'h00); end
        checks++; if (PCE !== 32'h64 || RS2E !== 5'd2) begin errors++; $display("FAIL flush_data: got %h/%0d want 64/2", PCE, RS2E); end
        FlushE = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        drive(32'h0060_01B3, 32'h68); tick();   // add x3,x0,x6
        checks++; if (RD2E !== 32'h99 || ctrl !== 8'h80) begin errors++; $display("FAIL flush_write: got %h/%h want 99/80", RD2E, ctrl); end
    endtask

    task automatic test_illegal();
        drive(32'hFFFF_FFFF, 32'h100); tick();
        checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL illegal_ctrl: got %h want %h", ctrl, 8'h00); end
        checks++; if (PCE !== 32'h100 || PCPlus4E !== 32'h104) begin errors++; $display("FAIL illegal_pc: got %h/%h want 100/104", PCE, PCPlus4E); end
    endtask

    task automatic test_reset_midrun();
        drive(32'h0020_81B3, 32'h40); tick();
        checks++; if (PCE !== 32'h40 || ctrl !== 8'h80) begin errors++; $display("FAIL pre_reset: got %h/%h want 40/80", PCE, ctrl); end
        wb(1'b1, 5'd1, 32'hAA);
        rst = 1'b0;
        #1;
        checks++; if (ctrl !== 8'h00 || PCE !== 32'h0) begin errors++; $display("FAIL midrst_now: got %h/%h want 00/0", ctrl, PCE); end
        checks++; if (RD1E !== 32'h0 || RD2E !== 32'h0 || RDE !== 5'd0) begin errors++; $display("FAIL midrst_data: got %h/%h/%0d want 0/0/0", RD1E, RD2E, RDE); end
        tick();
        rst = 1'b1;
        wb(1'b0, 5'd0, 32'h0);
        tick();
        checks++; if (RD1E !== 32'h0 || RD2E !== 32'h0) begin errors++; $display("FAIL regs_cleared: got %h/%h want 0/0", RD1E, RD2E); end
    endtask

    initial begin
        test_reset();
        test_alu_decode();
        test_bypass();
        test_lw_sw();
        test_beq_flush();
        test_illegal();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
